// File: rtl/perf_pkg.sv
// Shared constants and types for the performance monitor.
package perf_pkg;

  // Number of counters and their read indices
  localparam int unsigned NUM_CNT    = 5;
  localparam int unsigned IDX_CYCLE  = 0;
  localparam int unsigned IDX_LW     = 1;
  localparam int unsigned IDX_BR     = 2;
  localparam int unsigned IDX_FLUSH  = 3;
  localparam int unsigned IDX_RETIRE = 4;

  // Monitor run state
  typedef enum logic {
    StRun    = 1'b0,
    StFrozen = 1'b1
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating counter with sticky saturation flag; never wraps.
module sat_counter #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned INC_W = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic [INC_W-1:0] i_inc,
  output logic [CNT_W-1:0] o_value,
  output logic             o_sat
);

  localparam logic [CNT_W:0] MaxVal = {1'b0, {CNT_W{1'b1}}};

  logic [CNT_W-1:0] r_value;
  logic             r_sat;
  logic [CNT_W:0]   w_sum;
  logic             w_hit;

  // One extra bit so a multi-lane increment that overshoots is still seen
  assign w_sum = {1'b0, r_value} + (CNT_W+1)'(i_inc);
  assign w_hit = (i_inc != '0) && (w_sum >= MaxVal);

  // Accumulate, clamping at all-ones and latching the sticky flag
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_value <= '0;
      r_sat   <= 1'b0;
    end else if (w_hit) begin
      r_value <= '1;
      r_sat   <= 1'b1;
    end else begin
      r_value <= w_sum[CNT_W-1:0];
    end
  end

  assign o_value = r_value;
  assign o_sat   = r_sat;

endmodule

// File: rtl/perf_mon.sv
// Pipeline performance monitor: five saturating event counters, a freeze
// on end-of-program, and a one-cycle-latency indexed read port.
module perf_mon
  import perf_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [LANES-1:0] i_lwstall,
  input  logic [LANES-1:0] i_brstall,
  input  logic             i_stall,
  input  logic [LANES-1:0] i_bra_op,
  input  logic [LANES-1:0] i_retire,
  input  logic             i_ecall,
  input  logic             i_clr,
  input  logic             i_rd_req,
  input  logic [2:0]       i_rd_idx,
  output logic             o_rd_ack,
  output logic [CNT_W-1:0] o_rd_data,
  output logic             o_rd_sat,
  output logic             o_frozen
);

  localparam int unsigned POP_W = $clog2(LANES + 1);

  state_e           r_state;
  logic             r_frozen;
  logic             r_rd_ack;
  logic [CNT_W-1:0] r_rd_data;
  logic             r_rd_sat;

  logic             w_count;
  logic [POP_W-1:0] w_pop;
  logic [POP_W-1:0] w_inc   [NUM_CNT];
  logic [CNT_W-1:0] w_value [NUM_CNT];
  logic [NUM_CNT-1:0] w_sat;

  // clr wins over counting in the same cycle
  assign w_count = (r_state == StRun) && i_en && !i_clr;

  // Number of lanes retiring this cycle
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      w_pop = w_pop + POP_W'(i_retire[i]);
    end
  end

  // Per-counter increment for this cycle; zero when not counting
  always_comb begin
    w_inc[IDX_CYCLE]  = POP_W'(w_count);
    w_inc[IDX_LW]     = POP_W'(w_count && (|i_lwstall));
    w_inc[IDX_BR]     = POP_W'(w_count && (|i_brstall));
    w_inc[IDX_FLUSH]  = POP_W'(w_count && !i_stall && (|i_bra_op));
    w_inc[IDX_RETIRE] = w_count ? w_pop : '0;
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    sat_counter #(
      .CNT_W (CNT_W),
      .INC_W (POP_W)
    ) u_cnt (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (i_clr),
      .i_inc   (w_inc[g]),
      .o_value (w_value[g]),
      .o_sat   (w_sat[g])
    );
  end

  // RUN/FROZEN state machine with registered frozen flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StRun;
      r_frozen <= 1'b0;
    end else if (i_clr) begin
      r_state  <= StRun;
      r_frozen <= 1'b0;
    end else if ((r_state == StRun) && i_ecall) begin
      r_state  <= StFrozen;
      r_frozen <= 1'b1;
    end
  end

  // Read port: captures the pre-update value; data holds between reads
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ack  <= 1'b0;
      r_rd_data <= '0;
      r_rd_sat  <= 1'b0;
    end else begin
      r_rd_ack <= i_rd_req;
      if (i_rd_req) begin
        if (i_rd_idx < 3'(NUM_CNT)) begin
          r_rd_data <= w_value[i_rd_idx];
          r_rd_sat  <= w_sat[i_rd_idx];
        end else begin
          r_rd_data <= '0;
          r_rd_sat  <= 1'b0;
        end
      end
    end
  end

  assign o_rd_ack  = r_rd_ack;
  assign o_rd_data = r_rd_data;
  assign o_rd_sat  = r_rd_sat;
  assign o_frozen  = r_frozen;

endmodule

// File: tb/tb_perf_mon.sv
// Self-checking bench for perf_mon with a cycle-level reference model.
module tb_perf_mon;

  localparam int unsigned LANES = 2;
  localparam int unsigned CNT_W = 8;
  localparam longint MAXV = (longint'(1) << CNT_W) - 1;

  logic             clk;
  logic             rst, en, stall, ecall, clr, rd_req;
  logic [LANES-1:0] lwstall, brstall, bra_op, retire;
  logic [2:0]       rd_idx;
  logic             rd_ack, rd_sat, frozen;
  logic [CNT_W-1:0] rd_data;

  int n_checks;
  int n_errors;

  // Reference model state
  longint m_cnt [5];
  bit     m_sat [5];
  bit     m_frozen;
  bit     m_ack;
  longint m_rd;
  bit     m_rsat;

  perf_mon #(
    .LANES (LANES),
    .CNT_W (CNT_W)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_en      (en),
    .i_lwstall (lwstall),
    .i_brstall (brstall),
    .i_stall   (stall),
    .i_bra_op  (bra_op),
    .i_retire  (retire),
    .i_ecall   (ecall),
    .i_clr     (clr),
    .i_rd_req  (rd_req),
    .i_rd_idx  (rd_idx),
    .o_rd_ack  (rd_ack),
    .o_rd_data (rd_data),
    .o_rd_sat  (rd_sat),
    .o_frozen  (frozen)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply one clock edge's worth of behaviour to the model
  task automatic model_step();
    longint inc [5];
    longint nv;
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        m_cnt[i] = 0;
        m_sat[i] = 0;
      end
      m_frozen = 0;
      m_ack    = 0;
      m_rd     = 0;
      m_rsat   = 0;
    end else begin
      m_ack = rd_req;
      if (rd_req) begin
        if (rd_idx < 5) begin
          m_rd   = m_cnt[rd_idx];
          m_rsat = m_sat[rd_idx];
        end else begin
          m_rd   = 0;
          m_rsat = 0;
        end
      end
      if (clr) begin
        for (int i = 0; i < 5; i++) begin
          m_cnt[i] = 0;
          m_sat[i] = 0;
        end
        m_frozen = 0;
      end else begin
        if (!m_frozen && en) begin
          inc[0] = 1;
          inc[1] = (lwstall != 0) ? 1 : 0;
          inc[2] = (brstall != 0) ? 1 : 0;
          inc[3] = (!stall && bra_op != 0) ? 1 : 0;
          inc[4] = $countones(retire);
          for (int i = 0; i < 5; i++) begin
            nv = m_cnt[i] + inc[i];
            if (inc[i] > 0 && nv >= MAXV) begin
              m_cnt[i] = MAXV;
              m_sat[i] = 1;
            end else begin
              m_cnt[i] = nv;
            end
          end
        end
        if (ecall && !m_frozen) m_frozen = 1;
      end
    end
  endtask

  // Every-cycle comparison of all outputs against the model
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("frozen", longint'(frozen), longint'(m_frozen));
      chk("rd_ack", longint'(rd_ack), longint'(m_ack));
      chk("rd_data", longint'(rd_data), m_rd);
      chk("rd_sat", longint'(rd_sat), longint'(m_rsat));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  // Single read with a hand-computed literal expectation; entered at negedge
  task automatic do_read(input int idx, input longint exp_d, input longint exp_s);
    rd_req = 1'b1;
    rd_idx = 3'(idx);
    @(posedge clk);
    #2;
    chk($sformatf("lit_ack[%0d]", idx), longint'(rd_ack), 1);
    chk($sformatf("lit_data[%0d]", idx), longint'(rd_data), exp_d);
    chk($sformatf("lit_sat[%0d]", idx), longint'(rd_sat), exp_s);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  initial begin
    longint exp35 [8];
    exp35 = '{10, 0, 0, 0, 0, 0, 0, 0};
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; en = 1'b0; stall = 1'b0; ecall = 1'b0; clr = 1'b0; rd_req = 1'b0;
    lwstall = '0; brstall = '0; bra_op = '0; retire = '0; rd_idx = '0;
    tick(2);
    rst = 1'b0;
    chk("rst_frozen", longint'(frozen), 0);
    chk("rst_ack", longint'(rd_ack), 0);
    chk("rst_data", longint'(rd_data), 0);

    // 10 idle counted cycles, then back-to-back reads of every index
    en = 1'b1;
    tick(10);
    en = 1'b0;
    for (int i = 0; i < 8; i++) do_read(i, exp35[i], 0);

    // Multi-lane retire
    pulse_clr();
    en = 1'b1;
    retire = 2'b11;
    tick(4);
    retire = 2'b01;
    tick(3);
    retire = 2'b00;
    en = 1'b0;
    do_read(4, 11, 0);
    do_read(0, 7, 0);

    // Stall and flush events
    pulse_clr();
    en = 1'b1;
    lwstall = 2'b01;
    tick(3);
    lwstall = 2'b00;
    brstall = 2'b10;
    tick(2);
    brstall = 2'b00;
    bra_op = 2'b11;
    stall = 1'b1;
    tick(1);
    stall = 1'b0;
    tick(2);
    bra_op = 2'b00;
    en = 1'b0;
    do_read(1, 3, 0);
    do_read(2, 2, 0);
    do_read(3, 2, 0);
    do_read(0, 8, 0);

    // ecall freezes; clr resumes
    pulse_clr();
    en = 1'b1;
    tick(4);
    ecall = 1'b1;
    tick(1);
    ecall = 1'b0;
    tick(20);
    en = 1'b0;
    do_read(0, 5, 0);
    chk("lit_frozen_hi", longint'(frozen), 1);
    pulse_clr();
    chk("lit_frozen_lo", longint'(frozen), 0);
    do_read(0, 0, 0);

    // Saturation of a single-step counter
    en = 1'b1;
    tick(260);
    en = 1'b0;
    do_read(0, 255, 1);
    do_read(1, 0, 0);

    // Saturation by an overshooting two-lane retire
    pulse_clr();
    en = 1'b1;
    retire = 2'b01;
    tick(254);
    en = 1'b0;
    retire = 2'b00;
    do_read(4, 254, 0);
    en = 1'b1;
    retire = 2'b11;
    tick(1);
    en = 1'b0;
    retire = 2'b00;
    do_read(4, 255, 1);

    // clr + ecall + read in one cycle
    pulse_clr();
    en = 1'b1;
    tick(7);
    clr = 1'b1;
    ecall = 1'b1;
    rd_req = 1'b1;
    rd_idx = 3'd0;
    @(posedge clk);
    #2;
    chk("lit_clr_ack", longint'(rd_ack), 1);
    chk("lit_clr_data", longint'(rd_data), 7);
    @(negedge clk);
    clr = 1'b0;
    ecall = 1'b0;
    rd_req = 1'b0;
    tick(3);
    en = 1'b0;
    chk("lit_clr_run", longint'(frozen), 0);
    do_read(0, 3, 0);

    // Reset overrides clr, ecall and a pending read
    rst = 1'b1;
    clr = 1'b1;
    ecall = 1'b1;
    rd_req = 1'b1;
    rd_idx = 3'd0;
    tick(1);
    rst = 1'b0;
    clr = 1'b0;
    ecall = 1'b0;
    rd_req = 1'b0;
    chk("lit_rst_ack", longint'(rd_ack), 0);
    chk("lit_rst_data", longint'(rd_data), 0);
    chk("lit_rst_frozen", longint'(frozen), 0);
    tick(1);
    chk("lit_rst_noack", longint'(rd_ack), 0);
    do_read(0, 0, 0);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/perf_mon.md
PERF_MON -- requirements
Module: perf_mon

Interface
REQ-001 Parameter LANES, default 2, number of issue lanes observed.
REQ-002 Parameter CNT_W, default 32, width of every counter (legal range 8..64).
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset; synchronous, active-high.
REQ-005 Port en  input  1  count enable; counters advance only while high and in RUN.
REQ-006 Port lwstall  input  LANES  per-lane load-use stall indication.
REQ-007 Port brstall  input  LANES  per-lane stall-before-branch indication.
REQ-008 Port stall  input  1  global pipeline stall.
REQ-009 Port bra_op  input  LANES  per-lane branch/jump taken in current cycle.
REQ-010 Port retire  input  LANES  per-lane instruction retired this cycle.
REQ-011 Port ecall  input  1  end-of-program indication; freezes counters.
REQ-012 Port clr  input  1  clear all counters and sticky flags; resume RUN.
REQ-013 Port rd_req  input  1  read request, single-cycle pulse.
REQ-014 Port rd_idx  input  3  counter index to read.
REQ-015 Port rd_ack  output  1  read data valid, one-cycle pulse.
REQ-016 Port rd_data  output  CNT_W  counter value read.
REQ-017 Port rd_sat  output  1  sticky saturation flag of the counter read.
REQ-018 Port frozen  output  1  high while in FROZEN.

Function
REQ-019 Five counters SHALL exist: 0 CYCLE, 1 LW_STALL, 2 BR_STALL, 3 BR_FLUSH, 4 RETIRE.
REQ-020 Per counted cycle: CYCLE +1; LW_STALL +1 if |lwstall; BR_STALL +1 if |brstall; BR_FLUSH +1 if !stall & |bra_op; RETIRE +popcount(retire).
REQ-021 A counted cycle SHALL be one with state RUN, en=1, clr=0.
REQ-022 Every counter SHALL saturate at 2^CNT_W-1 (including multi-lane RETIRE increments overshooting) and set its sticky sat flag; it never wraps.
REQ-023 FSM states RUN and FROZEN; RUN->FROZEN on ecall=1 with clr=0; FROZEN->RUN only on clr.
REQ-024 The ecall cycle itself SHALL be counted if en=1; from the next cycle all counters hold.
REQ-025 clr SHALL zero all counters and sat flags next edge, enter RUN, and take priority over simultaneous ecall and counting events.
REQ-026 rd_req in cycle N SHALL give rd_ack=1 with rd_data/rd_sat in cycle N+1, reflecting counter value at edge N (pre-update).
REQ-027 Reads SHALL be accepted in any state, back-to-back every cycle; rd_req during clr returns the pre-clear value.
REQ-028 rd_idx 5..7 SHALL return rd_ack=1, rd_data=0, rd_sat=0.
REQ-029 rd_ack SHALL be 0 in any cycle not preceded by rd_req; rd_data holds last value otherwise.

Reset
REQ-030 On rst: state RUN, all counters 0, sat flags 0, rd_ack 0, rd_data 0, rd_sat 0, frozen 0.
REQ-031 rst SHALL override clr, ecall and rd_req; a read pending at reset is discarded.

Structure
REQ-032 Package perf_pkg SHALL hold counter index constants, NUM_CNT=5, and the RUN/FROZEN state type.
REQ-033 Sub-module sat_counter (parameters CNT_W, INC_W; inputs clr, inc; outputs value, sat) SHALL implement one saturating counter, instanced five times.
REQ-034 Popcount of retire SHALL be width $clog2(LANES+1) and zero-extended before addition.

Verification
REQ-035 Reset, en=1 for 10 cycles, no events -> read idx0 gives 10, idx1..4 give 0.
REQ-036 LANES=2, retire=2'b11 for 4 cycles, 2'b01 for 3 cycles -> RETIRE=11.
REQ-037 lwstall=2'b01 for 3 cycles, brstall=2'b10 for 2 cycles, bra_op=2'b11 with stall=1 once and stall=0 twice -> LW_STALL=3, BR_STALL=2, BR_FLUSH=2.
REQ-038 ecall at cycle 5 of counting, then 20 more cycles -> CYCLE=5, frozen=1; clr -> CYCLE reads 0, frozen=0.
REQ-039 CNT_W=8, 260 counted cycles -> CYCLE=255, rd_sat=1; RETIRE at 254 with retire=2'b11 -> 255, sat=1.
REQ-040 clr and ecall in same cycle plus rd_req idx0 with CYCLE=7 -> rd_data=7 next cycle, then state RUN and CYCLE counts from 0.
